// File: rtl/restoring_divider_pkg.sv
// Shared types and constants for the restoring divider.
package restoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned N_DEFAULT = 64;

    // Widest operand the divide-by-zero fill constant covers.
    localparam int unsigned MAX_N = 1024;

    // Quotient reported for a zero divisor; truncated to n bits at use.
    localparam logic [MAX_N-1:0] DBZ_QUOTIENT = '1;

    // Iteration counter width: counts n-1 down to 0.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Issue/complete handshake bundle between the ALU and the divider.
interface restoring_divider_if
    import restoring_divider_pkg::*;
#(
    parameter int unsigned n = N_DEFAULT
);
    logic         start;
    logic [n-1:0] dividend;
    logic [n-1:0] divisor;
    logic         busy;
    logic         done;
    logic [n-1:0] quotient;
    logic [n-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_borrow_lookahead_subtractor.sv
// a - b as a + ~b + 1 using generate/propagate terms; borrow is the inverted carry-out.
module borrow_lookahead_subtractor #(
    parameter int unsigned width = 65
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] diff,
    output logic             borrow_out
);
    logic [width-1:0] g;
    logic [width-1:0] p;
    logic [width:0]   c;

    assign g = a & ~b;
    assign p = a ^ ~b;

    // Carry chain from the generate/propagate terms, carry-in fixed at 1.
    always_comb begin
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < int'(width); i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign diff       = p ^ c[width-1:0];
    assign borrow_out = ~c[width];
endmodule

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int unsigned n = N_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    restoring_divider_if.slave bus
);
    localparam int unsigned cnt_w = cnt_width(n);

    state_t           state;
    logic [cnt_w-1:0] cnt;
    logic [n-1:0]     rem;
    logic [n-1:0]     quo;
    logic [n-1:0]     dvd;
    logic [n-1:0]     dvs;

    logic [n:0]       partial;
    logic [n:0]       diff;
    logic             borrow;
    logic [n-1:0]     step_rem;
    logic [n-1:0]     step_quo;
    logic             unused_msb;

    // Bring down the next dividend bit and trial-subtract the divisor.
    assign partial = {rem, dvd[cnt]};

    borrow_lookahead_subtractor #(
        .width(n + 1)
    ) u_sub (
        .a          (partial),
        .b          ({1'b0, dvs}),
        .diff       (diff),
        .borrow_out (borrow)
    );

    // Either branch is below the divisor, so the top bit is always zero.
    assign step_rem   = borrow ? partial[n-1:0] : diff[n-1:0];
    assign step_quo   = {quo[n-2:0], ~borrow};
    assign unused_msb = diff[n] ^ partial[n];

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            rem             <= '0;
            quo             <= '0;
            dvd             <= '0;
            dvs             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        dvd             <= bus.dividend;
                        dvs             <= bus.divisor;
                        quo             <= '0;
                        rem             <= '0;
                        cnt             <= cnt_w'(n - 1);
                        bus.div_by_zero <= 1'b0;
                        if (bus.divisor == '0) begin
                            // Zero divisor short-circuits straight to completion.
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.quotient    <= n'(DBZ_QUOTIENT);
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            state    <= RUN;
                            bus.busy <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    if (cnt == '0) begin
                        state         <= DONE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.quotient  <= step_quo;
                        bus.remainder <= step_rem;
                    end else begin
                        cnt <= cnt - cnt_w'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random checks of the restoring divider at n=8 and n=64.
module tb_restoring_divider;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    restoring_divider_if #(.n(8))  bus8 ();
    restoring_divider_if #(.n(64)) bus64 ();

    restoring_divider #(.n(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    restoring_divider #(.n(64)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One cycle; start is a single-cycle pulse.
    task automatic tick();
        @(negedge clk);
        cyc++;
        bus8.start  = 1'b0;
        bus64.start = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] d, input bit track);
        exp_t e;
        bus8.dividend = a;
        bus8.divisor  = d;
        bus8.start    = 1'b1;
        cyc = 0;
        if (track) begin
            e.z = (d == 8'd0);
            e.q = e.z ? 64'hFF : 64'(a / d);
            e.r = e.z ? 64'(a) : 64'(a % d);
            sb.push_back(e);
        end
    endtask

    task automatic issue64(input logic [63:0] a, input logic [63:0] d);
        exp_t e;
        bus64.dividend = a;
        bus64.divisor  = d;
        bus64.start    = 1'b1;
        cyc = 0;
        e.z = 1'b0;
        e.q = a / d;
        e.r = a % d;
        sb.push_back(e);
    endtask

    // Busy through cycles first..lat-1, done in cycle lat, results from the scoreboard.
    task automatic check_op8(input string tag, input int lat, input int first);
        exp_t e;
        for (int k = first; k < lat; k++) begin
            tick();
            chk({tag, ".busy"}, 64'(bus8.busy), 64'd1);
            chk({tag, ".no_done"}, 64'(bus8.done), 64'd0);
        end
        tick();
        chk({tag, ".done"}, 64'(bus8.done), 64'd1);
        chk({tag, ".busy_low"}, 64'(bus8.busy), 64'd0);
        chk({tag, ".sb_entry"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".quotient"}, 64'(bus8.quotient), e.q);
            chk({tag, ".remainder"}, 64'(bus8.remainder), e.r);
            chk({tag, ".dbz"}, 64'(bus8.div_by_zero), 64'(e.z));
        end
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        logic        early;
        exp_t        e;

        rst = 1'b1;
        bus8.start = 1'b0;   bus8.dividend = '0;  bus8.divisor = '0;
        bus64.start = 1'b0;  bus64.dividend = '0; bus64.divisor = '0;
        repeat (3) tick();

        chk("reset.busy", 64'(bus8.busy), 64'd0);
        chk("reset.done", 64'(bus8.done), 64'd0);
        chk("reset.quotient", 64'(bus8.quotient), 64'd0);
        chk("reset.remainder", 64'(bus8.remainder), 64'd0);
        chk("reset.dbz", 64'(bus8.div_by_zero), 64'd0);
        chk("reset64.busy", 64'(bus64.busy), 64'd0);
        rst = 1'b0;
        tick();

        // 100 / 7
        issue8(8'd100, 8'd7, 1'b1);
        check_op8("d100_7", 9, 1);
        tick();
        chk("d100_7.idle_done", 64'(bus8.done), 64'd0);

        // Back-to-back: second start lands in the first done cycle.
        issue8(8'd255, 8'd1, 1'b1);
        check_op8("d255_1", 9, 1);
        issue8(8'd5, 8'd9, 1'b1);
        check_op8("d5_9", 9, 1);
        tick();

        // Divide by zero, then a normal op clears the flag.
        issue8(8'h5A, 8'd0, 1'b1);
        check_op8("dbz", 1, 1);
        tick();
        chk("dbz.idle_done", 64'(bus8.done), 64'd0);
        chk("dbz.flag_held", 64'(bus8.div_by_zero), 64'd1);
        chk("dbz.quot_held", 64'(bus8.quotient), 64'hFF);
        issue8(8'd6, 8'd3, 1'b1);
        tick();
        chk("d6_3.flag_cleared", 64'(bus8.div_by_zero), 64'd0);
        chk("d6_3.busy1", 64'(bus8.busy), 64'd1);
        check_op8("d6_3", 9, 2);
        tick();

        // A start during RUN is ignored.
        issue8(8'd200, 8'd13, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("d200_13.busy", 64'(bus8.busy), 64'd1);
        end
        bus8.dividend = 8'd9;
        bus8.divisor  = 8'd3;
        bus8.start    = 1'b1;
        check_op8("d200_13", 9, 5);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("d200_13.hold_q", 64'(bus8.quotient), 64'd15);
            chk("d200_13.hold_r", 64'(bus8.remainder), 64'd5);
            chk("d200_13.idle_busy", 64'(bus8.busy), 64'd0);
            chk("d200_13.idle_done", 64'(bus8.done), 64'd0);
        end

        // Reset mid-run discards the operation.
        issue8(8'd77, 8'd4, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.busy", 64'(bus8.busy), 64'd0);
        chk("midrst.done", 64'(bus8.done), 64'd0);
        chk("midrst.quotient", 64'(bus8.quotient), 64'd0);
        chk("midrst.remainder", 64'(bus8.remainder), 64'd0);
        chk("midrst.dbz", 64'(bus8.div_by_zero), 64'd0);
        for (int k = 7; k <= 15; k++) begin
            tick();
            chk("midrst.no_done", 64'(bus8.done), 64'd0);
        end
        issue8(8'd50, 8'd6, 1'b1);
        check_op8("d50_6", 9, 1);
        tick();

        // n=64 random operands with edge-case mixes.
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom(), $urandom()};
            d = {$urandom(), $urandom()};
            case (i % 4)
                0: begin
                    a = 64'($urandom());
                    d = a + 64'd1 + 64'($urandom());
                end
                1: d = 64'h8000_0000_0000_0000;
                2: a = '1;
                default: d = d >> $urandom_range(63, 0);
            endcase
            if (d == 64'd0) d = 64'd1;
            issue64(a, d);
            early = 1'b0;
            for (int k = 1; k <= 64; k++) begin
                tick();
                if (bus64.done) early = 1'b1;
            end
            chk("n64.early_done", 64'(early), 64'd0);
            tick();
            chk("n64.done65", 64'(bus64.done), 64'd1);
            chk("n64.sb_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("n64.quotient", bus64.quotient, e.q);
                chk("n64.remainder", bus64.remainder, e.r);
            end
            chk("n64.identity", bus64.quotient * d + bus64.remainder, a);
            chk("n64.rem_lt_div", 64'(bus64.remainder < d), 64'd1);
            chk("n64.dbz", 64'(bus64.div_by_zero), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
